noc_input_port: RTL
===================

Name: noc_input_port

Overview:
- Router input port: the upstream-facing end of the output-arbiter protocol.
- Accepts flits from the neighbour's output port via write_request/data_in and drives buffer_full back as that port's destination_full.
- Buffers whole packets (store-and-forward), XY-routes the head flit and raises a one-hot request to the five output arbiters.
- Streams the packet out while granted, then releases the request.

Parameters:
- packet_size, 32, packet width in bits
- flit_size, 4, flit width in bits; flit_number = packet_size/flit_size = 8
- fifo_depth, 16, flit storage; must be >= flit_number, power of two
- local_x, 0, router X coordinate (2 bits)
- local_y, 0, router Y coordinate (2 bits)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- write_request  in  1  upstream writes data_in this cycle
- data_in  in  flit_size  incoming flit
- buffer_full  out  1  FIFO full; drives upstream destination_full
- request  out  5  one-hot output request: bit0 local, bit1 north, bit2 south, bit3 east, bit4 west
- grant  in  1  grant bit from the arbiter this port is requesting
- flit_taken  in  1  output side consumed data_out this cycle
- data_out  out  flit_size  FIFO head flit, show-ahead
- overflow_error  out  1  sticky; a write arrived while full

Behaviour:
- Reset (synchronous, active-high) clears:
  - FIFO pointers and count to 0
  - state to IDLE, sent counter to 0
  - request = 0, buffer_full = 0, overflow_error = 0
  - data_out is don't-care until the first write
  - Reset mid-packet discards all buffered flits; request drops the cycle after reset is sampled.
- FIFO:
  - Push when write_request && !buffer_full.
  - Pop when flit_taken && state == SENDING; flit_taken in any other state is ignored.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo fifo_depth.
  - buffer_full = (count == fifo_depth), registered from count.
  - Write while full: flit dropped, overflow_error set and held until reset.
  - data_out = mem[rd_ptr], combinational from the pointer.
- Head flit format: [3:2] dest_x, [1:0] dest_y.
- State machine:
  - IDLE: when count >= flit_number, go to ROUTE. The count includes a push in the same cycle only from the next cycle.
  - ROUTE (one cycle): decode the head flit into a registered one-hot dir, then go to REQUEST. XY routing:
    - dest_x > local_x -> east
    - dest_x < local_x -> west
    - else dest_y > local_y -> north
    - else dest_y < local_y -> south
    - else local
  - REQUEST: request = dir. When grant == 1, go to SENDING with sent = 0.
  - SENDING: request = dir, except masked to 0 when sent == flit_number-1, so the arbiter does not re-grant on the last flit.
    - Each pop increments sent.
    - On the pop with sent == flit_number-1: clear sent and go to IDLE.
    - A grant drop in SENDING is ignored; the packet is already committed.
  - Back-to-back packets: IDLE re-evaluates count on the next cycle. Minimum bubble is 2 cycles (IDLE, ROUTE) before the next request.
- No underflow is possible: SENDING is entered only with a full packet resident.
- Latency: the last flit pushed to request high is 3 cycles (count update, IDLE->ROUTE, ROUTE->REQUEST).

Test Plan:
- Reset, then push 8 flits with head 4'b0100 (local_x = 0, local_y = 0) -> request = 5'b01000 (east) on the 3rd cycle after the last push; buffer_full = 0.
- Grant, then flit_taken for 8 cycles -> data_out shows flits 0..7 in order; request = 0 in the cycle with sent = 7; state is IDLE and count is 0 afterwards.
- Push 16 flits with no grant -> buffer_full = 1 after the 16th. A 17th write -> dropped, overflow_error = 1. Reads later return the original 16 flits.
- Routing with local_x = 1, local_y = 1, one packet per case:
  - head 4'b0101 -> local (5'b00001)
  - head 4'b0110 -> north (5'b00010)
  - head 4'b0100 -> south (5'b00100)
  - head 4'b0001 -> west (5'b10000)
- Simultaneous push and pop during SENDING, with flit_taken toggling -> count stays correct, no flit lost or duplicated, and the second packet is requested 2 cycles after the first completes.
- Assert reset in SENDING at sent = 4 -> next cycle: request = 0, buffer_full = 0, count = 0, overflow_error = 0.

Source files
------------

// File: rtl/noc_input_port.sv
// Router input port: store-and-forward flit FIFO, XY-routes the head flit, one-hot request to output arbiters.
// Request rises 3 cycles after a packet's last flit is written; buffer_full backpressures upstream, writes while full are dropped and flagged.
module noc_input_port #(
   parameter int         packet_size = 32,
   parameter int         flit_size   = 4,
   parameter int         fifo_depth  = 16,
   parameter logic [1:0] local_x     = 2'd0,
   parameter logic [1:0] local_y     = 2'd0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write_request,
   input  logic [flit_size-1:0] data_in,
   output logic                 buffer_full,
   output logic [4:0]           request,
   input  logic                 grant,
   input  logic                 flit_taken,
   output logic [flit_size-1:0] data_out,
   output logic                 overflow_error
);

   localparam int flit_number = packet_size / flit_size;
   localparam int ptr_w       = $clog2(fifo_depth);
   localparam int cnt_w       = $clog2(fifo_depth + 1);
   localparam int sent_w      = (flit_number > 1) ? $clog2(flit_number) : 1;

   typedef struct packed {
      logic [1:0] dest_x;
      logic [1:0] dest_y;
   } hdr_t;

   typedef enum logic [1:0] {IDLE, ROUTE, REQUEST, SENDING} state_t;

   logic [flit_size-1:0] mem [fifo_depth];
   logic [ptr_w-1:0]     wr_ptr, rd_ptr;
   logic [cnt_w-1:0]     count, count_next;
   state_t               state, state_next;
   logic [4:0]           dir, dir_next;
   logic [sent_w-1:0]    sent, sent_next;
   logic                 push, pop, last_flit;
   hdr_t                 hdr;

   assign push      = write_request && !buffer_full;
   assign pop       = flit_taken && (state == SENDING);
   assign last_flit = (sent == sent_w'(flit_number - 1));
   assign data_out  = mem[rd_ptr];
   assign hdr       = hdr_t'(data_out[3:0]);

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + cnt_w'(1);
         2'b01:   count_next = count - cnt_w'(1);
         default: count_next = count;
      endcase
   end

   // buffer_full is registered from the next count so it always matches count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         buffer_full    <= 1'b0;
         overflow_error <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_w'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
         count       <= count_next;
         buffer_full <= (count_next == cnt_w'(fifo_depth));
         if (write_request && buffer_full) overflow_error <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   function automatic logic [4:0] xy_route(input hdr_t h);
      if (h.dest_x > local_x)      return 5'b01000;
      else if (h.dest_x < local_x) return 5'b10000;
      else if (h.dest_y > local_y) return 5'b00010;
      else if (h.dest_y < local_y) return 5'b00100;
      else                         return 5'b00001;
   endfunction

   always_comb begin
      state_next = state;
      dir_next   = dir;
      sent_next  = sent;
      request    = '0;
      case (state)
         IDLE: begin
            if (count >= cnt_w'(flit_number)) state_next = ROUTE;
         end
         ROUTE: begin
            dir_next   = xy_route(hdr);
            state_next = REQUEST;
         end
         REQUEST: begin
            request = dir;
            if (grant) begin
               state_next = SENDING;
               sent_next  = '0;
            end
         end
         SENDING: begin
            // Drop the request on the last flit so the arbiter cannot re-grant us.
            request = last_flit ? 5'b00000 : dir;
            if (pop) begin
               if (last_flit) begin
                  sent_next  = '0;
                  state_next = IDLE;
               end else begin
                  sent_next = sent + sent_w'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sent  <= '0;
         dir   <= '0;
      end else begin
         state <= state_next;
         sent  <= sent_next;
         dir   <= dir_next;
      end
   end

endmodule
